// File: rtl/mux_rr_arb_pkg.sv
// Shared mode encodings and sizing helper for the N-channel arbitrated mux.
// Imported by the arbiter and the top-level output stage.
package mux_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Ceiling log2, used to size the channel index.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/mux_rr_arb_arbiter.sv
// Combinational round-robin / fixed-priority grant over N_CH requesters; owns the rr pointer.
// Grant is same-cycle; the pointer only moves when the top reports a completed transfer.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N_CH = 4,
    localparam int SELW = sel_width(N_CH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] req,
    input  logic            mode,
    input  logic            advance,
    output logic [N_CH-1:0] grant,
    output logic [SELW-1:0] idx
);

    logic [SELW-1:0] ptr;

    // Walk the channels starting at ptr (rr) or at 0 (fixed); first requester wins.
    always_comb begin
        logic            found;
        int              cand;
        logic [SELW-1:0] cand_idx;
        grant    = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (mode == MODE_FIXED) begin
                cand = k;
            end else begin
                cand = (int'(ptr) + k) % N_CH;
            end
            cand_idx = cand[SELW-1:0];
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (advance && mode == MODE_RR) begin
            ptr <= (idx == SELW'(N_CH - 1)) ? '0 : idx + SELW'(1);
        end
    end

endmodule

// File: rtl/mux_rr_arb.sv
// N-channel valid/ready mux with rr/fixed arbitration into one registered output word, 1-cycle latency.
// While the output word is stalled (out_valid & ~out_ready) every in_ready is held low.
module mux_rr_arb
    import mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    localparam int SELW = sel_width(N_CH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_sel,
    input  logic                  out_ready
);

    logic             load;
    logic             xfer;
    logic [N_CH-1:0]  grant;
    logic [SELW-1:0]  grant_idx;
    logic [WIDTH-1:0] ch_data [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Register can take a new word when empty or when its current word leaves this cycle.
    assign load     = ~out_valid | out_ready;
    assign in_ready = (reset && load) ? grant : '0;
    assign xfer     = |(in_valid & in_ready);

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (in_valid),
        .mode    (mode),
        .advance (xfer),
        .grant   (grant),
        .idx     (grant_idx)
    );

    // Idle load clears valid only; data/sel keep the last delivered word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= ch_data[grant_idx];
                out_sel   <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_arb.sv
// Bench for mux_rr_arb: directed vector table, hand-written corner sequences, random run vs a model.
module tb_mux_rr_arb;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           reset;
    logic           mode;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_ready;

    int n_cmp;
    int n_fail;

    mux_rr_arb #(.N_CH(N), .WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_data_a0();
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'hA0 + 8'(i);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b1;
        mode      = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic         mode;
        logic [N-1:0] iv;
        logic         ordy;
        logic [N-1:0] exp_rdy;
        logic         exp_vld;
        logic [1:0]   exp_sel;
        logic [W-1:0] exp_dat;
    } vec_t;

    vec_t vecs[16];

    // Behavioural reference state for the random run.
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_sel;
    int           m_ptr;
    logic [N-1:0] pend;
    logic [W-1:0] pend_dat [N];

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        reset     = 1'b0;
        mode      = 1'b0;
        in_valid  = '1;
        out_ready = 1'b1;
        set_data_a0();

        // Reset held with all channels requesting.
        #1;
        chk("rst_rdy_a", 32'(in_ready), 0);
        chk("rst_vld_a", 32'(out_valid), 0);
        #12;
        chk("rst_rdy_b", 32'(in_ready), 0);
        chk("rst_dat_b", 32'(out_data), 0);
        #13;
        chk("rst_vld_c", 32'(out_valid), 0);
        chk("rst_sel_c", 32'(out_sel), 0);
        #1;
        reset = 1'b1;

        // Vector table: rr fairness, fixed priority, sparse/wrap, idle, ptr hold.
        vecs[0]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
        vecs[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
        vecs[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
        vecs[3]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
        vecs[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
        vecs[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
        vecs[6]  = '{1'b1, 4'b1110, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
        vecs[7]  = '{1'b1, 4'b1110, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
        vecs[8]  = '{1'b1, 4'b1110, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
        vecs[9]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
        vecs[10] = '{1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
        vecs[11] = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
        vecs[12] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA0};
        vecs[13] = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
        vecs[14] = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
        vecs[15] = '{1'b0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
        for (int v = 0; v < 16; v++) begin
            @(negedge clk);
            mode      = vecs[v].mode;
            in_valid  = vecs[v].iv;
            out_ready = vecs[v].ordy;
            #1;
            chk($sformatf("vec%0d_rdy", v), 32'(in_ready), 32'(vecs[v].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_vld", v), 32'(out_valid), 32'(vecs[v].exp_vld));
            chk($sformatf("vec%0d_sel", v), 32'(out_sel), 32'(vecs[v].exp_sel));
            chk($sformatf("vec%0d_dat", v), 32'(out_data), 32'(vecs[v].exp_dat));
        end

        // Backpressure: ch2 word parked for 3 cycles, then drain+fill on one edge.
        do_reset();
        mode = 1'b0;
        in_valid = 4'b0100;
        in_data[2*W +: W] = 8'h5C;
        out_ready = 1'b1;
        #1;
        chk("bp_first_rdy", 32'(in_ready), 32'b0100);
        @(posedge clk);
        #1;
        chk("bp_first_dat", 32'(out_data), 32'h5C);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 4'b1111;
            set_data_a0();
            #1;
            chk($sformatf("bp_hold%0d_rdy", c), 32'(in_ready), 0);
            chk($sformatf("bp_hold%0d_vld", c), 32'(out_valid), 1);
            chk($sformatf("bp_hold%0d_dat", c), 32'(out_data), 32'h5C);
            chk($sformatf("bp_hold%0d_sel", c), 32'(out_sel), 2);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(in_ready), 32'b1000);
        @(posedge clk);
        #1;
        chk("bp_release_dat", 32'(out_data), 32'hA3);
        chk("bp_release_sel", 32'(out_sel), 3);

        // Async reset between edges during an rr stream.
        do_reset();
        in_valid = 4'b1111;
        set_data_a0();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_vld", 32'(out_valid), 0);
        chk("arst_rdy", 32'(in_ready), 0);
        chk("arst_dat", 32'(out_data), 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("arst_first_rdy", 32'(in_ready), 32'b0001);
        @(posedge clk);
        #1;
        chk("arst_first_sel", 32'(out_sel), 0);
        chk("arst_first_dat", 32'(out_data), 32'hA0);

        // Random run against the reference model.
        do_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = 0;
        m_ptr   = 0;
        pend    = '0;
        for (int i = 0; i < N; i++) pend_dat[i] = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            int  best;
            int  best_dist;
            logic load;
            if (cyc != 0) @(negedge clk);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]     = 1'b1;
                    pend_dat[i] = 8'($urandom);
                end
                in_data[i*W +: W] = pend[i] ? pend_dat[i] : 8'($urandom);
            end
            in_valid = pend;
            #1;
            chk("rnd_vld", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("rnd_dat", 32'(out_data), 32'(m_data));
                chk("rnd_sel", 32'(out_sel), 32'(m_sel));
            end
            // Winner: lowest index (fixed) or smallest forward distance from ptr (rr).
            load = !m_valid || out_ready;
            best = -1;
            best_dist = N;
            for (int i = 0; i < N; i++) begin
                if (pend[i]) begin
                    int d;
                    d = (mode == 1'b1) ? i : (i - m_ptr + N) % N;
                    if (d < best_dist) begin
                        best_dist = d;
                        best = i;
                    end
                end
            end
            chk("rnd_rdy", 32'(in_ready), (load && best >= 0) ? (32'd1 << best) : 32'd0);
            if (load) begin
                if (best >= 0) begin
                    m_valid    = 1'b1;
                    m_data     = pend_dat[best];
                    m_sel      = best;
                    pend[best] = 1'b0;
                    if (mode == 1'b0) m_ptr = (best + 1) % N;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
